// File: rtl/regfile_sb.sv
// General-purpose register file with a per-register pending-write scoreboard.
// Reads are combinational, and a firing writeback is bypassed to the read ports in the same cycle.
module regfile_sb #(
  parameter int BITWIDTH   = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [BITWIDTH-1:0]   rdata1,
  output logic [BITWIDTH-1:0]   rdata2,
  output logic                  rs1_ready,
  output logic                  rs2_ready,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [BITWIDTH-1:0]   wb_data
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  // Writeback handshake: a transfer fires on a cycle where wb_valid && wb_ready.
  // wb_ready is a registered flag that rises on the first edge out of reset.
  // It is masked by rst_n so that nothing is accepted while reset is held.
  logic [BITWIDTH-1:0] regs_q [NUM_REGS];
  logic [BITWIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                wb_ready_q;
  logic                wb_ready_d;
  logic                wb_fire;
  logic                wb_wr;
  logic                iss_set;

  assign wb_ready = wb_ready_q & rst_n;
  assign wb_fire  = wb_valid & wb_ready;
  assign wb_wr    = wb_fire && (wb_addr != '0);
  assign iss_set  = iss_valid && (iss_rd != '0);

  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    wb_ready_d = 1'b1;
    if (wb_wr) begin
      regs_d[wb_addr] = wb_data;
      busy_d[wb_addr] = 1'b0;
    end
    // Applied after the clear so a same-index issue keeps the register busy.
    if (iss_set) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q     <= '{default: '0};
      busy_q     <= '0;
      wb_ready_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      wb_ready_q <= wb_ready_d;
    end
  end

  always_comb begin
    rdata1    = regs_q[raddr1];
    rs1_ready = ~busy_q[raddr1];
    if (raddr1 == '0) begin
      rdata1    = '0;
      rs1_ready = 1'b1;
    end else if (wb_fire && (wb_addr == raddr1)) begin
      rdata1    = wb_data;
      rs1_ready = 1'b1;
    end
  end

  always_comb begin
    rdata2    = regs_q[raddr2];
    rs2_ready = ~busy_q[raddr2];
    if (raddr2 == '0) begin
      rdata2    = '0;
      rs2_ready = 1'b1;
    end else if (wb_fire && (wb_addr == raddr2)) begin
      rdata2    = wb_data;
      rs2_ready = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed testbench for regfile_sb: reset, write/read, bypass, scoreboard and mid-operation reset.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        rs1_ready;
  logic        rs2_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_sb #(.BITWIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change at +1, checks at +2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0;
    iss_rd    = '0;
    wb_valid  = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    raddr1 = '0;
    raddr2 = '0;
    tick();
    tick();
    n_checks++;
    if (wb_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_wb_ready_low: got %b want 0", wb_ready);
    end
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #1;
      n_checks++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
        n_fail++; $display("FAIL reset_rdata[%0d]: got %h/%h want 0/0", i, rdata1, rdata2);
      end
      n_checks++;
      if (rs1_ready !== 1'b1 || rs2_ready !== 1'b1) begin
        n_fail++; $display("FAIL reset_ready[%0d]: got %b/%b want 1/1", i, rs1_ready, rs2_ready);
      end
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (wb_ready !== 1'b0) begin
      n_fail++; $display("FAIL release_wb_ready_before_edge: got %b want 0", wb_ready);
    end
    tick();
    n_checks++;
    if (wb_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_wb_ready_after_edge: got %b want 1", wb_ready);
    end
  endtask

  task automatic test_write();
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    raddr1 = 5'd5;
    #1;
    n_checks++;
    if (rdata1 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL write_x5: got %h want deadbeef", rdata1);
    end
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h12345678;
    raddr2 = 5'd0;
    #1;
    n_checks++;
    if (rdata2 !== 32'h0 || rs2_ready !== 1'b1) begin
      n_fail++; $display("FAIL write_x0_bypass: got %h/%b want 0/1", rdata2, rs2_ready);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rdata2 !== 32'h0) begin
      n_fail++; $display("FAIL write_x0_read: got %h want 0", rdata2);
    end
  endtask

  task automatic test_bypass();
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h11110000;
    tick();
    wb_data = 32'hA5A5A5A5;
    raddr1 = 5'd7;
    #1;
    n_checks++;
    if (rdata1 !== 32'hA5A5A5A5 || rs1_ready !== 1'b1) begin
      n_fail++; $display("FAIL bypass_x7: got %h/%b want a5a5a5a5/1", rdata1, rs1_ready);
    end
    // Drop valid briefly inside the cycle to see the stored value.
    wb_valid = 1'b0;
    #1;
    n_checks++;
    if (rdata1 !== 32'h11110000) begin
      n_fail++; $display("FAIL bypass_old_x7: got %h want 11110000", rdata1);
    end
    wb_valid = 1'b1;
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rdata1 !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL bypass_after_x7: got %h want a5a5a5a5", rdata1);
    end
  endtask

  task automatic test_scoreboard();
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick();
    idle_inputs();
    raddr2 = 5'd3;
    #1;
    n_checks++;
    if (rs2_ready !== 1'b0) begin
      n_fail++; $display("FAIL sb_x3_busy: got %b want 0", rs2_ready);
    end
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
    #1;
    n_checks++;
    if (rs2_ready !== 1'b1 || rdata2 !== 32'h11) begin
      n_fail++; $display("FAIL sb_x3_fire: got %b/%h want 1/11", rs2_ready, rdata2);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rs2_ready !== 1'b1 || rdata2 !== 32'h11) begin
      n_fail++; $display("FAIL sb_x3_after: got %b/%h want 1/11", rs2_ready, rdata2);
    end
    // Issue with rd=0 never makes x0 busy.
    iss_valid = 1'b1; iss_rd = 5'd0;
    tick();
    idle_inputs();
    raddr1 = 5'd0;
    #1;
    n_checks++;
    if (rs1_ready !== 1'b1) begin
      n_fail++; $display("FAIL sb_x0_issue: got %b want 1", rs1_ready);
    end
  endtask

  task automatic test_same_edge();
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    raddr1 = 5'd9;
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h22;
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rs1_ready !== 1'b0 || rdata1 !== 32'h22) begin
      n_fail++; $display("FAIL same_idx_x9: got %b/%h want 0/22", rs1_ready, rdata1);
    end
    // Different indices on one edge: set x10, clear x9.
    iss_valid = 1'b1; iss_rd = 5'd10;
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h33;
    raddr2 = 5'd10;
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rs1_ready !== 1'b1 || rdata1 !== 32'h33) begin
      n_fail++; $display("FAIL diff_idx_x9: got %b/%h want 1/33", rs1_ready, rdata1);
    end
    n_checks++;
    if (rs2_ready !== 1'b0) begin
      n_fail++; $display("FAIL diff_idx_x10: got %b want 0", rs2_ready);
    end
  endtask

  task automatic test_dup_issue();
    iss_valid = 1'b1; iss_rd = 5'd12;
    tick();
    tick();
    idle_inputs();
    raddr1 = 5'd12;
    raddr2 = 5'd13;
    wb_valid = 1'b1; wb_addr = 5'd12; wb_data = 32'h44;
    tick();
    wb_addr = 5'd13; wb_data = 32'h55;
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rs1_ready !== 1'b1 || rdata1 !== 32'h44) begin
      n_fail++; $display("FAIL dup_issue_x12: got %b/%h want 1/44", rs1_ready, rdata1);
    end
    n_checks++;
    if (rs2_ready !== 1'b1 || rdata2 !== 32'h55) begin
      n_fail++; $display("FAIL nonbusy_wb_x13: got %b/%h want 1/55", rs2_ready, rdata2);
    end
  endtask

  task automatic test_reset_mid();
    iss_valid = 1'b1; iss_rd = 5'd1;
    tick();
    iss_rd = 5'd2;
    tick();
    idle_inputs();
    wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'hFF;
    tick();
    idle_inputs();
    raddr1 = 5'd1;
    raddr2 = 5'd4;
    #1;
    n_checks++;
    if (rs1_ready !== 1'b0 || rdata2 !== 32'hFF) begin
      n_fail++; $display("FAIL pre_reset_state: got %b/%h want 0/ff", rs1_ready, rdata2);
    end
    rst_n = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd6; wb_data = 32'hBEEF;
    raddr1 = 5'd6;
    #1;
    n_checks++;
    if (wb_ready !== 1'b0 || rdata1 !== 32'h0) begin
      n_fail++; $display("FAIL wb_during_reset: got %b/%h want 0/0", wb_ready, rdata1);
    end
    tick();
    rst_n = 1'b1;
    idle_inputs();
    raddr1 = 5'd1;
    raddr2 = 5'd2;
    #1;
    n_checks++;
    if (rs1_ready !== 1'b1 || rs2_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy_clear: got %b/%b want 1/1", rs1_ready, rs2_ready);
    end
    raddr1 = 5'd4;
    raddr2 = 5'd6;
    #1;
    n_checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      n_fail++; $display("FAIL reset_regs_clear: got %h/%h want 0/0", rdata1, rdata2);
    end
    n_checks++;
    if (wb_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_wb_ready: got %b want 0", wb_ready);
    end
    tick();
    n_checks++;
    if (wb_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_wb_ready_rise: got %b want 1", wb_ready);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    raddr1 = '0;
    raddr2 = '0;
    idle_inputs();
    test_reset();
    test_write();
    test_bypass();
    test_scoreboard();
    test_same_edge();
    test_dup_issue();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
